branch_target_lut: RTL
======================

BRANCH_TARGET_LUT -- requirements
Module: branch_target_lut

Interface
REQ-001: Parameter AW, default 4, index width; DEPTH = 2**AW entries.
REQ-002: Parameter D, default 10, target/PC width.
REQ-003: clk  input  1  single clock; all state on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: rd_en  input  1  lookup request.
REQ-006: rd_addr  input  AW  entry index for lookup.
REQ-007: pc  input  D  current PC, sampled with rd_en.
REQ-008: rd_valid  output  1  lookup result valid (one-cycle pulse).
REQ-009: rd_target  output  D  resolved branch target.
REQ-010: rd_hit  output  1  addressed entry was programmed.
REQ-011: wr_en  input  1  entry program strobe.
REQ-012: wr_addr  input  AW  entry index to program.
REQ-013: wr_data  input  D  absolute target or two's-complement offset.
REQ-014: wr_rel  input  1  1 = wr_data is a PC-relative offset.
REQ-015: busy  output  1  table initialising; requests ignored.

Function
REQ-016: FSM states INIT and READY; reset enters INIT with clear counter = 0.
REQ-017: INIT clears one entry (valid=0, rel=0, data=0) per cycle, counter 0..DEPTH-1; after entry DEPTH-1, next state is READY; busy = 1 exactly while in INIT (DEPTH cycles).
REQ-018: In INIT, rd_en and wr_en are ignored; rd_valid stays 0.
REQ-019: In READY, wr_en writes data, rel and valid=1 at wr_addr on the clock edge; rewriting an entry overwrites it.
REQ-020: Lookup latency is one cycle: rd_en at edge N gives rd_valid=1 with rd_target/rd_hit held for the cycle after N; otherwise rd_valid=0, rd_target/rd_hit hold their last values.
REQ-021: Hit, absolute entry: rd_target = stored data.
REQ-022: Hit, relative entry: rd_target = (pc + stored data) mod 2**D; the offset is already D bits wide, so wrap-around is silent.
REQ-023: Miss (valid=0): rd_hit=0, rd_target = (pc + 1) mod 2**D (fall-through).
REQ-024: Same-cycle wr_en and rd_en at the same address: the lookup returns the newly written entry (write bypass).
REQ-025: Back-to-back rd_en every cycle is sustained at full throughput.

Reset
REQ-026: rst_n low asynchronously forces rd_valid=0, rd_hit=0, rd_target=0, busy=1, state INIT, counter 0.
REQ-027: Reset asserted mid-INIT or mid-READY discards all entries; INIT restarts from entry 0 after release.

Configuration
REQ-028: Macro BTL_REL_EN defined: per-entry rel bit stored and REQ-022 applies.
REQ-029: BTL_REL_EN undefined: no rel storage and no adder for REQ-022; wr_rel is ignored and every hit returns stored data unchanged; miss behaviour (REQ-023) is unchanged.

Structure
REQ-030: Package btl_pkg holds the FSM state enum (INIT, READY), the entry struct (valid, rel, data), and the default AW/D constants.
REQ-031: Sub-module btl_regfile holds DEPTH entries, with one write port (shared by INIT clear and wr_en) and one combinational read port; branch_target_lut holds the FSM, bypass, adder and output registers.

Verification (AW=4, D=10)
REQ-032: Release reset -> busy=1 for exactly 16 cycles, then 0; rd_en pulsed during INIT -> no rd_valid.
REQ-033: Write addr 2 = 80 absolute; then rd_en addr 2, pc=7 -> next cycle rd_valid=1, rd_target=80, rd_hit=1.
REQ-034: rd_en addr 5 (never written), pc=100 -> rd_target=101, rd_hit=0; pc=1023 -> rd_target=0.
REQ-035: BTL_REL_EN: addr 3 = 10'b1111111011 (-5) relative, pc=4 -> rd_target=1023; addr 9 = 20 relative, pc=4 -> 24; without macro, addr 9 -> 20.
REQ-036: Same cycle wr_en addr 7 = 59 and rd_en addr 7 -> rd_target=59, rd_hit=1.
REQ-037: Assert rst_n low during READY after programming -> outputs cleared immediately; after release, 16 busy cycles, then addr 2 lookup misses.

Source files
------------

// File: rtl/btl_pkg.sv
// Shared types and default sizing for the branch target lookup table.
// Relative-target support is enabled by defining BTL_REL_EN.
package btl_pkg;

    localparam int BTL_AW = 4;
    localparam int BTL_D  = 10;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             rel;
        logic [BTL_D-1:0] data;
    } entry_t;

endpackage

// File: rtl/btl_regfile.sv
// Entry storage: one write port, one combinational read port.
// The per-entry rel bit exists only when BTL_REL_EN is defined.
module btl_regfile
    import btl_pkg::*;
#(
    parameter int AW = BTL_AW,
    parameter int D  = BTL_D
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_valid,
`ifdef BTL_REL_EN
    input  logic          wr_rel,
    output logic          rd_rel,
`endif
    input  logic [D-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [D-1:0]  rd_data
);

    localparam int DEPTH = 2 ** AW;

    logic         valid_q [DEPTH];
    logic [D-1:0] data_q  [DEPTH];

    // No reset here: the INIT sweep clears every entry after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_q[wr_addr] <= wr_valid;
            data_q[wr_addr]  <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_addr];
    assign rd_data  = data_q[rd_addr];

`ifdef BTL_REL_EN
    logic rel_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rel_q[wr_addr] <= wr_rel;
        end
    end

    assign rd_rel = rel_q[rd_addr];
`endif

endmodule

// File: rtl/branch_target_lut.sv
// Branch target lookup table: INIT sweep, write bypass, one-cycle lookup.
// Define BTL_REL_EN to add PC-relative entries.
module branch_target_lut
    import btl_pkg::*;
#(
    parameter int AW = BTL_AW,
    parameter int D  = BTL_D
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [D-1:0]  pc,
    output logic          rd_valid,
    output logic [D-1:0]  rd_target,
    output logic          rd_hit,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_rel,
    output logic          busy
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clr_q;
    logic [AW-1:0] clr_d;

    logic          ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic          wvalid;
    logic [D-1:0]  wdata;
    logic          rf_valid;
    logic [D-1:0]  rf_data;

    logic          bypass;
    logic          hit;
    logic [D-1:0]  data;
    logic [D-1:0]  pc_inc;
    logic [D-1:0]  target;

    assign ready = (state_q == READY);
    assign busy  = ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

`ifdef BTL_REL_EN
    logic wrel;
    logic rf_rel;
    logic rel;
`else
    logic unused_rel;
    assign unused_rel = wr_rel;
`endif

    // INIT owns the single write port; host writes only once READY.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        we      = 1'b0;
        waddr   = wr_addr;
        wvalid  = 1'b1;
        wdata   = wr_data;
`ifdef BTL_REL_EN
        wrel    = wr_rel;
`endif
        unique case (state_q)
            INIT: begin
                we     = 1'b1;
                waddr  = clr_q;
                wvalid = 1'b0;
                wdata  = '0;
`ifdef BTL_REL_EN
                wrel   = 1'b0;
`endif
                clr_d  = clr_q + 1'b1;
                if (clr_q == {AW{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                we = wr_en;
            end
        endcase
    end

    btl_regfile #(
        .AW(AW),
        .D (D)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (we),
        .wr_addr (waddr),
        .wr_valid(wvalid),
`ifdef BTL_REL_EN
        .wr_rel  (wrel),
        .rd_rel  (rf_rel),
`endif
        .wr_data (wdata),
        .rd_addr (rd_addr),
        .rd_valid(rf_valid),
        .rd_data (rf_data)
    );

    assign bypass = ready && wr_en && (wr_addr == rd_addr);
    assign hit    = bypass ? 1'b1 : rf_valid;
    assign data   = bypass ? wr_data : rf_data;
    assign pc_inc = pc + {{(D-1){1'b0}}, 1'b1};

`ifdef BTL_REL_EN
    assign rel    = bypass ? wr_rel : rf_rel;
    assign target = !hit ? pc_inc : (rel ? pc + data : data);
`else
    assign target = hit ? data : pc_inc;
`endif

    // Target and hit hold their last values between lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_hit    <= 1'b0;
            rd_target <= '0;
        end else begin
            rd_valid <= ready && rd_en;
            if (ready && rd_en) begin
                rd_hit    <= hit;
                rd_target <= target;
            end
        end
    end

endmodule
